// File: rtl/toggle_event_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_event_decoder_if
//  Brief    : Event/handshake bundle between a toggle event decoder and its
//             downstream controller. The decoder side uses the slave modport.
//  Revision : 1.0 - initial release
// ============================================================================
interface toggle_event_decoder_if #(
   parameter int CNT_W  = 8,
   parameter int PEND_W = 4
);
   logic              tog_in;
   logic              level;
   logic              evt_pulse;
   logic [CNT_W-1:0]  evt_cnt;
   logic              pend_valid;
   logic              pend_ack;
   logic [PEND_W-1:0] pend_cnt;
   logic              ovf;

   // Controller / line driver side
   modport master (
      output tog_in,
      output pend_ack,
      input  level,
      input  evt_pulse,
      input  evt_cnt,
      input  pend_valid,
      input  pend_cnt,
      input  ovf
   );

   // Decoder side
   modport slave (
      input  tog_in,
      input  pend_ack,
      output level,
      output evt_pulse,
      output evt_cnt,
      output pend_valid,
      output pend_cnt,
      output ovf
   );
endinterface
`default_nettype wire

// File: rtl/toggle_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_event_decoder
//  Brief    : Receive-side decoder for a toggle-encoded event line. Every
//             level change of tog_in is one event. The line is synchronized,
//             optionally debounced, and each accepted toggle produces a
//             one-cycle pulse, bumps a wrapping event counter and queues a
//             pending event behind a valid/ack handshake.
//  Config   : TOG_DEBOUNCE_EN - when defined, a toggle is accepted only after
//             the synchronized line has differed from the filtered level for
//             DEB_CYCLES consecutive cycles. When undefined every change of
//             the synchronized line is accepted and DEB_CYCLES is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module toggle_event_decoder #(
   parameter int DEB_CYCLES = 4,
   parameter int CNT_W      = 8,
   parameter int PEND_W     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   toggle_event_decoder_if.slave bus
);

   localparam logic [PEND_W-1:0] c_PEND_MAX = {PEND_W{1'b1}};

   // Reject an out-of-range debounce length at elaboration time
   generate
      if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_deb_range_err
         $error("toggle_event_decoder: DEB_CYCLES must be in 1..255");
      end
   endgenerate

   logic              r_s1;
   logic              r_s2;
   logic              r_level;
   logic              r_evt_pulse;
   logic [CNT_W-1:0]  r_evt_cnt;
   logic [PEND_W-1:0] r_pend_cnt;
   logic              r_ovf;

   logic              w_acc;
   logic              w_ack;
   logic              w_sat;
   logic              w_pend_valid;

   // Two-flop synchronizer for the asynchronous toggle line
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= bus.tog_in;
         r_s2 <= r_s1;
      end
   end

`ifdef TOG_DEBOUNCE_EN
   localparam logic [7:0] c_DEB_LAST = 8'(DEB_CYCLES - 1);

   logic [7:0] r_dcnt;

   // Accept once the mismatch has persisted for DEB_CYCLES cycles
   assign w_acc = (r_s2 != r_level) && (r_dcnt == c_DEB_LAST);

   // Count consecutive cycles the synchronized line disagrees with level
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dcnt <= 8'd0;
      end else if ((r_s2 == r_level) || w_acc) begin
         r_dcnt <= 8'd0;
      end else begin
         r_dcnt <= r_dcnt + 8'd1;
      end
   end
`else
   // Without the filter, any disagreement is a toggle on this edge
   assign w_acc = (r_s2 != r_level);
`endif

   // Pending events are visible whenever the queue count is non-zero
   assign w_pend_valid = (r_pend_cnt != '0);
   assign w_ack        = bus.pend_ack & w_pend_valid;
   assign w_sat        = (r_pend_cnt == c_PEND_MAX);

   // Filtered level, one-cycle event pulse and wrapping event counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_level     <= 1'b0;
         r_evt_pulse <= 1'b0;
         r_evt_cnt   <= '0;
      end else begin
         r_evt_pulse <= w_acc;
         if (w_acc) begin
            r_level   <= ~r_level;
            r_evt_cnt <= r_evt_cnt + CNT_W'(1);
         end
      end
   end

   // Pending-event counter with saturation and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_cnt <= '0;
         r_ovf      <= 1'b0;
      end else if (w_acc && !w_ack) begin
         // A simultaneous ack frees a slot, so only an unacked event overflows
         if (w_sat) begin
            r_ovf <= 1'b1;
         end else begin
            r_pend_cnt <= r_pend_cnt + PEND_W'(1);
         end
      end else if (!w_acc && w_ack) begin
         r_pend_cnt <= r_pend_cnt - PEND_W'(1);
      end
   end

   assign bus.level      = r_level;
   assign bus.evt_pulse  = r_evt_pulse;
   assign bus.evt_cnt    = r_evt_cnt;
   assign bus.pend_valid = w_pend_valid;
   assign bus.pend_cnt   = r_pend_cnt;
   assign bus.ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_toggle_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_toggle_event_decoder
//  Brief    : Self-checking bench for toggle_event_decoder. Each driven toggle
//             that should be accepted pushes its expected pulse cycle, level
//             and event count into a scoreboard; a monitor pops and compares
//             on every evt_pulse. Handshake, saturation, wrap and reset
//             behaviour are checked directly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_event_decoder;

   localparam int DEB = 4;
`ifdef TOG_DEBOUNCE_EN
   localparam int LAT_E = DEB + 1;   // E0 -> pulse edge
   localparam int MID   = 3;         // cycles into debounce before reset
`else
   localparam int LAT_E = 2;
   localparam int MID   = 1;
`endif
   // Pulse is seen LAT_E edges after E0, and E0 is the edge after the drive
   localparam int PULSE_DLY = LAT_E + 1;

   typedef struct {
      int         cyc;
      logic       lvl;
      logic [7:0] cnt;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   exp_t       sb[$];
   logic       exp_level;
   logic [7:0] exp_cnt;

   toggle_event_decoder_if #(.CNT_W(8), .PEND_W(4)) bus ();

   toggle_event_decoder #(
      .DEB_CYCLES (DEB),
      .CNT_W      (8),
      .PEND_W     (4)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to time-stamp expected pulses
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_level"},      32'(bus.level),      32'd0);
      check({tag, "_evt_pulse"},  32'(bus.evt_pulse),  32'd0);
      check({tag, "_evt_cnt"},    32'(bus.evt_cnt),    32'd0);
      check({tag, "_pend_cnt"},   32'(bus.pend_cnt),   32'd0);
      check({tag, "_pend_valid"}, 32'(bus.pend_valid), 32'd0);
      check({tag, "_ovf"},        32'(bus.ovf),        32'd0);
   endtask

   // Flip the line, record the expected pulse, then hold for 'hold' cycles
   task automatic toggle(input int hold);
      bus.tog_in = ~bus.tog_in;
      exp_level  = ~exp_level;
      exp_cnt    = exp_cnt + 8'd1;
      sb.push_back('{cyc: cyc + PULSE_DLY, lvl: exp_level, cnt: exp_cnt});
      repeat (hold) @(negedge clk);
   endtask

   // Reset for three cycles; outputs must already be zero after the first
   task automatic do_reset(input logic tog_val, input string tag);
      bus.tog_in   = tog_val;
      bus.pend_ack = 1'b0;
      rst          = 1'b1;
      @(negedge clk);
      check_all_zero(tag);
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      exp_level = 1'b0;
      exp_cnt   = 8'd0;
      sb.delete();
   endtask

   // Scoreboard monitor: every pulse must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.evt_pulse === 1'b1) begin
            if (sb.size() == 0) begin
               check("spurious_pulse", 32'(bus.evt_pulse), 32'd0);
            end else begin
               e = sb.pop_front();
               check("pulse_cycle", 32'(cyc), 32'(e.cyc));
               check("pulse_level", 32'(bus.level), 32'(e.lvl));
               check("pulse_evt_cnt", 32'(bus.evt_cnt), 32'(e.cnt));
            end
         end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            check("missed_pulse", 32'(bus.evt_pulse), 32'd1);
            void'(sb.pop_front());
         end
      end
   end

   // Hard time limit so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.tog_in   = 1'b0;
      bus.pend_ack = 1'b0;
      exp_level    = 1'b0;
      exp_cnt      = 8'd0;
      rst          = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single toggle
      toggle(10);
      check("single_level",      32'(bus.level),      32'd1);
      check("single_evt_cnt",    32'(bus.evt_cnt),    32'd1);
      check("single_pend_cnt",   32'(bus.pend_cnt),   32'd1);
      check("single_pend_valid", 32'(bus.pend_valid), 32'd1);

      // Short pulse: rejected by the filter, or two toggles without it
      do_reset(1'b0, "rst_a");
`ifdef TOG_DEBOUNCE_EN
      bus.tog_in = 1'b1;
      repeat (3) @(negedge clk);
      bus.tog_in = 1'b0;
      repeat (10) @(negedge clk);
      check("glitch_level",   32'(bus.level),   32'd0);
      check("glitch_evt_cnt", 32'(bus.evt_cnt), 32'd0);
`else
      toggle(1);
      toggle(10);
      check("pulse1_level",   32'(bus.level),   32'd0);
      check("pulse1_evt_cnt", 32'(bus.evt_cnt), 32'd2);
`endif

      // Handshake drain
      do_reset(1'b0, "rst_b");
      repeat (3) toggle(10);
      check("hs_pend_cnt", 32'(bus.pend_cnt), 32'd3);
      bus.pend_ack = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check("hs_ack_pend_cnt",   32'(bus.pend_cnt),   32'((i < 3) ? (3 - i) : 0));
         check("hs_ack_pend_valid", 32'(bus.pend_valid), 32'((i < 3) ? 1 : 0));
      end
      bus.pend_ack = 1'b0;
      check("hs_ovf", 32'(bus.ovf), 32'd0);

      // Saturation and overflow
      do_reset(1'b0, "rst_c");
      repeat (15) toggle(7);
      check("sat15_pend_cnt", 32'(bus.pend_cnt), 32'd15);
      check("sat15_ovf",      32'(bus.ovf),      32'd0);
      toggle(7);
      check("sat16_pend_cnt", 32'(bus.pend_cnt), 32'd15);
      check("sat16_ovf",      32'(bus.ovf),      32'd1);
      check("sat16_evt_cnt",  32'(bus.evt_cnt),  32'd16);

      // Toggle and ack on the same edge while saturated
      do_reset(1'b0, "rst_d");
      repeat (15) toggle(7);
      toggle(PULSE_DLY - 1);
      bus.pend_ack = 1'b1;
      @(negedge clk);
      bus.pend_ack = 1'b0;
      check("coinc_pend_cnt", 32'(bus.pend_cnt), 32'd15);
      check("coinc_ovf",      32'(bus.ovf),      32'd0);
      repeat (3) @(negedge clk);

      // Event counter wrap
      do_reset(1'b0, "rst_e");
      repeat (256) toggle(7);
      check("wrap_evt_cnt", 32'(bus.evt_cnt), 32'd0);
      check("wrap_level",   32'(bus.level),   32'd0);
      check("wrap_ovf",     32'(bus.ovf),     32'd1);

      // Reset mid-debounce with the line still high: decoded once afterwards
      bus.tog_in = 1'b1;
      repeat (MID) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("midrst");
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      sb.delete();
      exp_level = 1'b1;
      exp_cnt   = 8'd1;
      sb.push_back('{cyc: cyc + PULSE_DLY, lvl: 1'b1, cnt: 8'd1});
      repeat (10) @(negedge clk);
      check("midrst_hi_evt_cnt", 32'(bus.evt_cnt), 32'd1);
      check("midrst_hi_level",   32'(bus.level),   32'd1);

      // Reset mid-debounce with the line back at 0: nothing is counted
      bus.tog_in = 1'b0;
      repeat (MID) @(negedge clk);
      do_reset(1'b0, "midrst_lo");
      repeat (10) @(negedge clk);
      check("midrst_lo_evt_cnt", 32'(bus.evt_cnt), 32'd0);
      check("midrst_lo_level",   32'(bus.level),   32'd0);

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
